// File: rtl/gpio_cfg_pkg.sv
// Shared state encoding and default sizing for the GPIO configuration chain loader.
package gpio_cfg_pkg;

  localparam int DEF_NUM_PADS      = 14;
  localparam int DEF_PAD_CTRL_BITS = 12;
  localparam int DEF_CLK_DIV       = 2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    SHIFT_LO,
    SHIFT_HI,
    LOAD,
    DONE
  } cfg_state_t;

endpackage

// File: rtl/gpio_cfg_clkdiv.sv
// Phase timer: counts mclk cycles while a timed state is active and flags the last cycle.
module gpio_cfg_clkdiv #(
  parameter int CLK_DIV = 2
) (
  input  logic mclk,
  input  logic resetn,
  input  logic run,
  input  logic long_phase,
  output logic phase_end
);

  // Wide enough for the double-length load phase (2*CLK_DIV-1) without wrapping.
  localparam int CW = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] SHORT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LONG_LAST  = CW'(2 * CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign phase_end = run && (cnt == (long_phase ? LONG_LAST : SHORT_LAST));

  always_ff @(posedge mclk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (!run || phase_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gpio_cfg_loader.sv
// Reads one config word per pad and shifts the whole gpio_control_block chain, then pulses load.
module gpio_cfg_loader
  import gpio_cfg_pkg::*;
#(
  parameter int NUM_PADS      = DEF_NUM_PADS,
  parameter int PAD_CTRL_BITS = DEF_PAD_CTRL_BITS,
  parameter int CLK_DIV       = DEF_CLK_DIV,
  localparam int AW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1,
  localparam int BW = (PAD_CTRL_BITS > 1) ? $clog2(PAD_CTRL_BITS) : 1
) (
  input  logic                     mclk,
  input  logic                     resetn,
  input  logic                     cfg_start,
  output logic [AW-1:0]            cfg_rd_addr,
  input  logic [PAD_CTRL_BITS-1:0] cfg_rd_data,
  output logic                     serial_clock,
  output logic                     serial_data,
  output logic                     serial_load,
  output logic                     busy,
  output logic                     done,
  output logic                     start_ovr
);

  localparam logic [AW-1:0] LAST_PAD = AW'(NUM_PADS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(PAD_CTRL_BITS - 1);

  cfg_state_t               state;
  logic [AW-1:0]            pad;
  logic [BW-1:0]            bit_idx;
  logic [PAD_CTRL_BITS-1:0] shreg;
  logic                     phase_end;
  logic                     timed;

  assign timed = (state == SHIFT_LO) || (state == SHIFT_HI) || (state == LOAD);

  gpio_cfg_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
    .mclk       (mclk),
    .resetn     (resetn),
    .run        (timed),
    .long_phase (state == LOAD),
    .phase_end  (phase_end)
  );

  // Address and data come straight from flops, so the outputs stay registered.
  assign cfg_rd_addr = pad;
  assign serial_data = shreg[PAD_CTRL_BITS-1];

  always_ff @(posedge mclk) begin
    if (!resetn) begin
      state        <= IDLE;
      pad          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      serial_clock <= 1'b0;
      serial_load  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      start_ovr    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cfg_start && state != IDLE) begin
        start_ovr <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (cfg_start) begin
            state     <= FETCH;
            pad       <= LAST_PAD;
            busy      <= 1'b1;
            start_ovr <= 1'b0;
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          shreg   <= cfg_rd_data;
          bit_idx <= LAST_BIT;
          state   <= SHIFT_LO;
        end
        SHIFT_LO: begin
          if (phase_end) begin
            serial_clock <= 1'b1;
            state        <= SHIFT_HI;
          end
        end
        // The falling edge is the only point where the data bit may advance.
        SHIFT_HI: begin
          if (phase_end) begin
            serial_clock <= 1'b0;
            if (bit_idx != '0) begin
              bit_idx <= bit_idx - 1'b1;
              shreg   <= shreg << 1;
              state   <= SHIFT_LO;
            end else if (pad != '0) begin
              pad   <= pad - 1'b1;
              state <= FETCH;
            end else begin
              serial_load <= 1'b1;
              state       <= LOAD;
            end
          end
        end
        LOAD: begin
          if (phase_end) begin
            serial_load <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_cfg_loader.sv
// Bench for gpio_cfg_loader: a pad-chain model checks latched words, timing and protocol rules.
module tb_gpio_cfg_loader;

  localparam int NP = 14;
  localparam int PB = 12;

  logic          mclk = 1'b0;
  logic          resetn = 1'b0;
  logic          cfg_start = 1'b0;
  logic [3:0]    cfg_rd_addr;
  logic [PB-1:0] cfg_rd_data;
  logic          serial_clock, serial_data, serial_load, busy, done, start_ovr;

  logic          cfg_start1 = 1'b0;
  logic [3:0]    cfg_rd_addr1;
  logic [PB-1:0] cfg_rd_data1;
  logic          serial_clock1, serial_data1, serial_load1, busy1, done1, start_ovr1;

  logic [PB-1:0] mem [NP];

  int checks = 0;
  int errors = 0;

  always #5 mclk = ~mclk;

  gpio_cfg_loader dut (
    .mclk(mclk), .resetn(resetn), .cfg_start(cfg_start), .cfg_rd_addr(cfg_rd_addr),
    .cfg_rd_data(cfg_rd_data), .serial_clock(serial_clock), .serial_data(serial_data),
    .serial_load(serial_load), .busy(busy), .done(done), .start_ovr(start_ovr)
  );

  gpio_cfg_loader #(.CLK_DIV(1)) dut_fast (
    .mclk(mclk), .resetn(resetn), .cfg_start(cfg_start1), .cfg_rd_addr(cfg_rd_addr1),
    .cfg_rd_data(cfg_rd_data1), .serial_clock(serial_clock1), .serial_data(serial_data1),
    .serial_load(serial_load1), .busy(busy1), .done(done1), .start_ovr(start_ovr1)
  );

  // Register file with one-cycle read latency.
  always @(posedge mclk) begin
    cfg_rd_data  <= mem[cfg_rd_addr];
    cfg_rd_data1 <= mem[cfg_rd_addr1];
  end

  // Chain of gpio_control_blocks: shift on serial_clock rise, latch every pad on serial_load rise.
  logic [NP*PB-1:0] chain = '0;
  logic [PB-1:0]    latched [NP] = '{default: '0};
  int sclk_rises, load_pulses, load_cycles, proto_viol;
  logic p_sclk = 1'b0, p_sload = 1'b0, p_sdata = 1'b0, p_rstn = 1'b0;

  always @(negedge mclk) begin
    if (resetn) begin
      if (serial_clock && !p_sclk) begin
        chain = {chain[NP*PB-2:0], serial_data};
        sclk_rises++;
      end
      if (serial_load) load_cycles++;
      if (serial_load && !p_sload) begin
        load_pulses++;
        for (int k = 0; k < NP; k++) latched[k] = chain[k*PB +: PB];
      end
      if (serial_load && serial_clock) proto_viol++;
      if (p_rstn && serial_data !== p_sdata && !(p_sclk && !serial_clock) &&
          !(!p_sclk && !serial_clock && busy && !serial_load)) proto_viol++;
    end
    p_sclk  = serial_clock;
    p_sload = serial_load;
    p_sdata = serial_data;
    p_rstn  = resetn;
  end

  logic [NP*PB-1:0] chain1 = '0;
  logic [PB-1:0]    latched1 [NP] = '{default: '0};
  int sclk_rises1, proto_viol1;
  logic p_sclk1 = 1'b0, p_sload1 = 1'b0;

  always @(negedge mclk) begin
    if (resetn) begin
      if (serial_clock1 && !p_sclk1) begin
        chain1 = {chain1[NP*PB-2:0], serial_data1};
        sclk_rises1++;
      end
      if (serial_load1 && !p_sload1)
        for (int k = 0; k < NP; k++) latched1[k] = chain1[k*PB +: PB];
      if (serial_load1 && serial_clock1) proto_viol1++;
    end
    p_sclk1  = serial_clock1;
    p_sload1 = serial_load1;
  end

  typedef struct {
    string      name;
    int         pattern;
    logic [PB-1:0] base;
    int         ovr_at;
    int         exp_done;
    int         exp_rises;
    int         exp_load_w;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // pattern 0: every pad = base, 1: pad k = base+k, 2: random words
  task automatic apply_stimulus(input int pattern, input logic [PB-1:0] base);
    for (int k = 0; k < NP; k++) begin
      case (pattern)
        0:       mem[k] = base;
        1:       mem[k] = base + PB'(k);
        default: mem[k] = PB'($urandom);
      endcase
    end
  endtask

  task automatic run_transfer(input int ovr_at, output int done_cyc);
    int cyc;
    sclk_rises = 0; load_pulses = 0; load_cycles = 0; proto_viol = 0;
    done_cyc = -1;
    @(negedge mclk); cfg_start = 1'b1;
    @(negedge mclk); cfg_start = 1'b0;
    cyc = 1;
    check("busy_first_cycle", busy, 1);
    check("ovr_cleared_on_start", start_ovr, 0);
    while (cyc <= 2000) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      cfg_start = (cyc == ovr_at);
      @(negedge mclk);
      cyc++;
    end
    cfg_start = 1'b0;
  endtask

  task automatic check_output(input string name, input logic exp_ovr, input int exp_w,
                              input int exp_rises, input int exp_done, input int done_cyc);
    int bad;
    bad = 0;
    for (int k = 0; k < NP; k++) if (latched[k] !== mem[k]) bad++;
    check({name, "_done_cycle"}, done_cyc, exp_done);
    check({name, "_sclk_rises"}, sclk_rises, exp_rises);
    check({name, "_load_pulses"}, load_pulses, 1);
    check({name, "_load_width"}, load_cycles, exp_w);
    check({name, "_pads_latched_bad"}, bad, 0);
    check({name, "_busy_in_done"}, busy, 1);
    check({name, "_start_ovr"}, start_ovr, exp_ovr);
    check({name, "_protocol"}, proto_viol, 0);
  endtask

  initial begin
    int dc;
    int cyc;
    int bad;
    logic [PB-1:0] snap [NP];

    vecs[0] = '{"all_c00",   0, 12'hC00, -1,  705, 168, 4, 1'b0};
    vecs[1] = '{"pad_k",     1, 12'h100, -1,  705, 168, 4, 1'b0};
    vecs[2] = '{"rand_a",    2, 12'h000, -1,  705, 168, 4, 1'b0};
    vecs[3] = '{"ovr_300",   2, 12'h000, 300, 705, 168, 4, 1'b1};
    vecs[4] = '{"all_fff",   0, 12'hFFF, -1,  705, 168, 4, 1'b0};
    vecs[5] = '{"rand_b",    2, 12'h000, -1,  705, 168, 4, 1'b0};

    apply_stimulus(0, '0);
    repeat (3) @(negedge mclk);
    check("reset_outputs", {serial_clock, serial_data, serial_load, busy, done, start_ovr, cfg_rd_addr}, 0);
    check("reset_outputs_fast", {serial_clock1, serial_load1, busy1, done1, start_ovr1, cfg_rd_addr1}, 0);
    resetn = 1'b1;
    repeat (2) @(negedge mclk);

    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i].pattern, vecs[i].base);
      run_transfer(vecs[i].ovr_at, dc);
      check_output(vecs[i].name, vecs[i].exp_ovr, vecs[i].exp_load_w, vecs[i].exp_rises,
                   vecs[i].exp_done, dc);
      @(negedge mclk);
      check({vecs[i].name, "_idle_after"}, {busy, done}, 0);
      if (vecs[i].exp_ovr) begin
        repeat (5) @(negedge mclk);
        check("ovr_sticky", start_ovr, 1);
      end
    end

    // A start landing in the DONE cycle is dropped but still flagged.
    apply_stimulus(1, 12'h3A0);
    run_transfer(-1, dc);
    check("done_cycle_case", dc, 705);
    cfg_start = 1'b1;
    @(negedge mclk); cfg_start = 1'b0;
    check("start_in_done_ovr", start_ovr, 1);
    check("start_in_done_not_busy", busy, 0);
    repeat (3) @(negedge mclk);
    check("start_in_done_stays_idle", busy, 0);

    // Reset in the middle of shifting: no load, pads keep their earlier words.
    for (int k = 0; k < NP; k++) snap[k] = latched[k];
    apply_stimulus(2, '0);
    load_pulses = 0;
    @(negedge mclk); cfg_start = 1'b1;
    @(negedge mclk); cfg_start = 1'b0;
    cyc = 1;
    while (cyc < 350) begin @(negedge mclk); cyc++; end
    resetn = 1'b0;
    @(negedge mclk);
    check("midshift_reset_outputs",
          {serial_clock, serial_data, serial_load, busy, done, start_ovr, cfg_rd_addr}, 0);
    resetn = 1'b1;
    repeat (20) @(negedge mclk);
    bad = 0;
    for (int k = 0; k < NP; k++) if (latched[k] !== snap[k]) bad++;
    check("midshift_no_load", load_pulses, 0);
    check("midshift_pads_unchanged", bad, 0);
    check("midshift_stays_idle", busy, 0);

    // CLK_DIV=1 instance: one cycle per phase.
    apply_stimulus(1, 12'h0A0);
    sclk_rises1 = 0; proto_viol1 = 0; dc = -1;
    @(negedge mclk); cfg_start1 = 1'b1;
    @(negedge mclk); cfg_start1 = 1'b0;
    cyc = 1;
    while (cyc <= 1000) begin
      if (done1) begin dc = cyc; break; end
      @(negedge mclk);
      cyc++;
    end
    bad = 0;
    for (int k = 0; k < NP; k++) if (latched1[k] !== mem[k]) bad++;
    check("fast_done_cycle", dc, 367);
    check("fast_sclk_rises", sclk_rises1, 168);
    check("fast_pads_latched_bad", bad, 0);
    check("fast_protocol", proto_viol1, 0);

    repeat (3) @(negedge mclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_cfg_loader.md
GPIO_CFG_LOADER -- requirements
Module: gpio_cfg_loader

Interface
REQ-001 Parameter NUM_PADS, default 14: number of gpio_control_block stages in the serial chain.
REQ-002 Parameter PAD_CTRL_BITS, default 12: configuration bits per pad stage.
REQ-003 Parameter CLK_DIV, default 2, legal range 1..255: mclk cycles per serial_clock phase (low or high).
REQ-004 mclk  input  1  block clock; the only clock.
REQ-005 resetn  input  1  synchronous, active-low reset.
REQ-006 cfg_start  input  1  one-cycle request to reprogram the whole chain.
REQ-007 cfg_rd_addr  output  $clog2(NUM_PADS)  pad index being fetched from the config register file.
REQ-008 cfg_rd_data  input  PAD_CTRL_BITS  config word for cfg_rd_addr; valid one mclk after the address is driven.
REQ-009 serial_clock  output  1  chain shift clock.
REQ-010 serial_data  output  1  chain serial data.
REQ-011 serial_load  output  1  chain load strobe.
REQ-012 busy  output  1  high from the accepted start through the done cycle.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 start_ovr  output  1  sticky flag, set when cfg_start arrives while busy; cleared on the next accepted start.

Function
REQ-015 FSM states: IDLE, FETCH, LATCH, SHIFT_LO, SHIFT_HI, LOAD, DONE.
REQ-016 IDLE, cfg_start=1 -> FETCH; pad index = NUM_PADS-1; busy rises the next cycle.
REQ-017 FETCH, 1 cycle: drive cfg_rd_addr = pad index.
REQ-018 LATCH, 1 cycle: capture cfg_rd_data into the shift register; bit index = PAD_CTRL_BITS-1.
REQ-019 Pad order: NUM_PADS-1 first, down to pad 0, so the first word shifted ends farthest down the chain.
REQ-020 Bit order within a pad: MSB first.
REQ-021 SHIFT_LO, CLK_DIV cycles: serial_clock=0; serial_data = current bit, stable for the whole low and high phase.
REQ-022 SHIFT_HI, CLK_DIV cycles: serial_clock=1.
REQ-023 After SHIFT_HI: next bit -> SHIFT_LO; last bit of a pad with pad index>0 -> FETCH with pad index-1; last bit of pad 0 -> LOAD.
REQ-024 LOAD, 2*CLK_DIV cycles: serial_load=1, serial_clock=0.
REQ-025 DONE, 1 cycle: done=1, busy=1; then -> IDLE.
REQ-026 Accepted start to done, in cycles: NUM_PADS*(2+PAD_CTRL_BITS*2*CLK_DIV) + 2*CLK_DIV + 1; defaults give 705.
REQ-027 cfg_start in any state other than IDLE is ignored and sets start_ovr.
REQ-028 cfg_start in the DONE cycle is also ignored and sets start_ovr.
REQ-029 serial_clock and serial_load are never high in the same cycle.
REQ-030 All outputs are registered, with no combinational path from inputs to outputs.
REQ-031 The phase counter width holds CLK_DIV*2-1 without wrap.
REQ-032 The pad index never goes below 0; no wrap is allowed.

Reset
REQ-033 resetn=0 at any mclk edge forces IDLE and clears the counters and shift register.
REQ-034 Output values under reset: serial_clock=0, serial_data=0, serial_load=0, busy=0, done=0, start_ovr=0, cfg_rd_addr=0.
REQ-035 Reset mid-shift abandons the transfer without issuing serial_load, so pad latches keep their previous values.

Structure
REQ-036 Package gpio_cfg_pkg holds the FSM state enum and the default NUM_PADS, PAD_CTRL_BITS and CLK_DIV constants.
REQ-037 One sub-module, gpio_cfg_clkdiv, holds the phase counter and issues phase_end ticks.
REQ-038 The FSM and datapath stay in gpio_cfg_loader.

Verification
REQ-039 Defaults, all pads configured 12'hC00, start -> 168 serial_clock rising edges; captured bit stream = 14 x (1100_0000_0000); one serial_load pulse 4 cycles wide; done at cycle 705.
REQ-040 Pad k configured 12'h100+k, start -> a chain model of 14 gpio_control_blocks latches 12'h100+k in every pad k.
REQ-041 Start held busy, second cfg_start at cycle 300 -> transfer unaffected; start_ovr=1 and stays 1 until the next accepted start.
REQ-042 resetn=0 at cycle 350 -> next cycle all outputs at their reset values; no serial_load pulse; chain model unchanged.
REQ-043 CLK_DIV=1 -> each phase lasts 1 cycle; done at cycle 14*26+2+1=367.
REQ-044 Assertion throughout all tests: serial_data changes only on a serial_clock falling edge or in SHIFT_LO entry.
REQ-045 Assertion throughout all tests: never serial_load && serial_clock.
